// File: rtl/reservoir_sequencer.sv
// Sequences one input sample across a time-multiplexed virtual-node reservoir,
// then streams every node state out over a valid/ready channel.
module reservoir_sequencer #(
  parameter int NUM_VIRTUAL_NODES = 100,
  parameter int DATA_WIDTH        = 32,
  parameter int NODE_DATA_WIDTH   = 12,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int TIMEOUT           = 15,
  localparam int IDX_W = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_clear,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [SAMPLE_WIDTH-1:0]      sample_data,
  input  logic [NUM_VIRTUAL_NODES-1:0] mask,
  output logic                         res_en,
  output logic [DATA_WIDTH-1:0]        res_din,
  input  logic                         res_valid,
  output logic                         res_load_node,
  output logic [NODE_DATA_WIDTH-1:0]   res_load_node_din,
  output logic [IDX_W-1:0]             res_node_sel,
  input  logic [NODE_DATA_WIDTH-1:0]   res_node_dout,
  output logic                         state_valid,
  input  logic                         state_ready,
  output logic [NODE_DATA_WIDTH-1:0]   state_data,
  output logic [IDX_W-1:0]             state_idx,
  output logic                         state_last,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VIRTUAL_NODES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INJECT,
    WAIT_ARM,
    WAIT_VALID,
    READOUT
  } state_t;

  state_t                         state_reg, state_next;
  logic [IDX_W-1:0]               k_reg, k_next;
  logic [TO_W-1:0]                tcnt_reg, tcnt_next;
  logic [SAMPLE_WIDTH-1:0]        sample_reg, sample_next;
  logic [NUM_VIRTUAL_NODES-1:0]   mask_reg, mask_next;
  logic                           timeout_reg, timeout_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      tcnt_reg    <= '0;
      sample_reg  <= '0;
      mask_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      k_reg       <= k_next;
      tcnt_reg    <= tcnt_next;
      sample_reg  <= sample_next;
      mask_reg    <= mask_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    k_next            = k_reg;
    tcnt_next         = tcnt_reg;
    sample_next       = sample_reg;
    mask_next         = mask_reg;
    timeout_next      = timeout_reg;
    sample_ready      = 1'b0;
    res_en            = 1'b0;
    res_din           = '0;
    res_load_node     = 1'b0;
    res_load_node_din = '0;
    res_node_sel      = k_reg;
    state_valid       = 1'b0;
    state_data        = '0;
    state_idx         = '0;
    state_last        = 1'b0;
    busy              = (state_reg != IDLE);
    timeout_err       = timeout_reg;

    case (state_reg)
      IDLE: begin
        // rst gating keeps ready low while the async reset is held
        sample_ready = ~start_clear & ~rst;
        if (start_clear) begin
          k_next     = '0;
          state_next = CLEAR;
        end else if (sample_valid) begin
          sample_next = sample_data;
          mask_next   = mask;
          k_next      = '0;
          state_next  = INJECT;
        end
      end
      CLEAR: begin
        res_load_node = 1'b1;
        if (k_reg == LAST_IDX) begin
          k_next     = '0;
          state_next = IDLE;
        end else begin
          k_next = k_reg + IDX_W'(1);
        end
      end
      INJECT: begin
        res_en     = 1'b1;
        res_din    = mask_reg[k_reg] ? DATA_WIDTH'(sample_reg) : '0;
        state_next = WAIT_ARM;
      end
      WAIT_ARM: begin
        // reservoir still shows the stale valid here; skip it
        tcnt_next  = '0;
        state_next = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (res_valid) begin
          if (k_reg == LAST_IDX) begin
            k_next     = '0;
            state_next = READOUT;
          end else begin
            k_next     = k_reg + IDX_W'(1);
            state_next = INJECT;
          end
        end else if (tcnt_reg == TO_LAST) begin
          timeout_next = 1'b1;
          k_next       = '0;
          state_next   = IDLE;
        end else begin
          tcnt_next = tcnt_reg + TO_W'(1);
        end
      end
      READOUT: begin
        state_valid = 1'b1;
        state_data  = res_node_dout;
        state_idx   = k_reg;
        state_last  = (k_reg == LAST_IDX);
        if (state_ready) begin
          if (k_reg == LAST_IDX) begin
            k_next     = '0;
            state_next = IDLE;
          end else begin
            k_next = k_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        k_next     = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Bench for reservoir_sequencer with four virtual nodes and a behavioural
// reservoir whose valid drops after each strobe and returns after a set latency.
module tb_reservoir_sequencer;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NW = 12;
  localparam int SW = 16;
  localparam int TO = 15;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_clear = 1'b0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [SW-1:0] sample_data = '0;
  logic [N-1:0]  mask = '0;
  logic          res_en;
  logic [DW-1:0] res_din;
  logic          res_valid;
  logic          res_load_node;
  logic [NW-1:0] res_load_node_din;
  logic [IW-1:0] res_node_sel;
  logic [NW-1:0] res_node_dout;
  logic          state_valid;
  logic          state_ready = 1'b0;
  logic [NW-1:0] state_data;
  logic [IW-1:0] state_idx;
  logic          state_last;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  reservoir_sequencer #(
    .NUM_VIRTUAL_NODES(N), .DATA_WIDTH(DW), .NODE_DATA_WIDTH(NW),
    .SAMPLE_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_clear(start_clear),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .mask(mask),
    .res_en(res_en), .res_din(res_din), .res_valid(res_valid),
    .res_load_node(res_load_node), .res_load_node_din(res_load_node_din),
    .res_node_sel(res_node_sel), .res_node_dout(res_node_dout),
    .state_valid(state_valid), .state_ready(state_ready),
    .state_data(state_data), .state_idx(state_idx), .state_last(state_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Behavioural reservoir: accumulates din into the selected node
  logic [NW-1:0] nodes [N];
  int unsigned   res_lat = 4;
  bit            res_dead = 1'b0;
  int unsigned   res_cnt;
  assign res_node_dout = nodes[res_node_sel];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b1;
      res_cnt   <= 0;
    end else if (res_en) begin
      res_valid <= 1'b0;
      res_cnt   <= res_dead ? 0 : res_lat;
      nodes[res_node_sel] <= nodes[res_node_sel] + res_din[NW-1:0];
    end else begin
      if (res_load_node) nodes[res_node_sel] <= res_load_node_din;
      if (res_cnt != 0) begin
        res_cnt <= res_cnt - 1;
        if (res_cnt == 1) res_valid <= 1'b1;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  logic [NW-1:0] exp_nodes [N];
  logic [SW-1:0] cur_sample;
  logic [N-1:0]  cur_mask;
  int inj_idx, rd_idx, clr_cnt, en_cnt, rd_cnt, since_en, hold_cnt;
  bit done, accepted, prev_hold;
  logic [NW-1:0] held_data;
  logic [IW-1:0] held_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, sample_ready, 0);
    check({tag, "_res_en"}, res_en, 0);
    check({tag, "_res_din"}, res_din, 0);
    check({tag, "_load"}, res_load_node, 0);
    check({tag, "_load_din"}, res_load_node_din, 0);
    check({tag, "_sel"}, res_node_sel, 0);
    check({tag, "_svalid"}, state_valid, 0);
    check({tag, "_sdata"}, state_data, 0);
    check({tag, "_sidx"}, state_idx, 0);
    check({tag, "_slast"}, state_last, 0);
    check({tag, "_timeout"}, timeout_err, 0);
  endtask

  // Settle after input changes and score the current cycle against the model
  task automatic observe();
    logic [DW-1:0] e;
    #1;
    if (en_cnt > 0) since_en++;
    if (res_en) begin
      check("inject_in_range", inj_idx < N, 1);
      if (inj_idx < N) begin
        e = cur_mask[inj_idx] ? DW'(cur_sample) : '0;
        check("res_din", res_din, e);
        if (cur_mask[inj_idx]) exp_nodes[inj_idx] = exp_nodes[inj_idx] + cur_sample[NW-1:0];
      end
      inj_idx++;
      en_cnt++;
      since_en = 0;
    end
    if (res_load_node) begin
      check("clear_in_range", clr_cnt < N, 1);
      check("clear_sel", res_node_sel, clr_cnt[IW-1:0]);
      check("clear_din", res_load_node_din, 0);
      if (clr_cnt < N) exp_nodes[clr_cnt] = '0;
      clr_cnt++;
    end
    if (prev_hold) begin
      check("hold_valid", state_valid, 1);
      check("hold_data", state_data, held_data);
      check("hold_idx", state_idx, held_idx);
    end
    prev_hold = 1'b0;
    if (state_valid) begin
      check("readout_in_range", rd_idx < N, 1);
      if (rd_idx < N) begin
        check("state_idx", state_idx, rd_idx[IW-1:0]);
        check("state_data", state_data, exp_nodes[rd_idx]);
        check("state_last", state_last, rd_idx == N - 1);
      end
      prev_hold = !state_ready;
      held_data = state_data;
      held_idx  = state_idx;
      if (!state_ready && rd_idx == 2) hold_cnt++;
      if (state_ready) begin
        if (rd_idx == N - 1) done = 1'b1;
        rd_idx++;
        rd_cnt++;
      end
    end
  endtask

  task automatic run_sample(input logic [SW-1:0] s, input logic [N-1:0] m, input int lat,
                            input bit with_clear, input bit dead, input bit hmode, input bit abort);
    bit was_acc;
    cur_sample = s; cur_mask = m; res_lat = lat; res_dead = dead;
    inj_idx = 0; rd_idx = 0; clr_cnt = 0; en_cnt = 0; rd_cnt = 0; hold_cnt = 0;
    since_en = -1000; done = 0; accepted = 0; prev_hold = 0;
    for (int c = 0; c < 600 && !done && !(dead && since_en >= 17); c++) begin
      @(negedge clk);
      was_acc      = accepted;
      start_clear  = (with_clear && c == 0) ? 1'b1 : (accepted && !dead && $urandom_range(0, 3) == 0);
      sample_valid = !accepted ? 1'b1 : (dead ? 1'b0 : 1'($urandom_range(0, 1)));
      sample_data  = !accepted ? s : SW'($urandom);
      mask         = !accepted ? m : N'($urandom);
      state_ready  = hmode ? !(rd_idx == 2 && hold_cnt < 3) : ($urandom_range(0, 3) != 0);
      observe();
      if (with_clear && c == 0) check("ready_on_clear_req", sample_ready, 0);
      if (was_acc && !(dead && since_en == 17)) begin
        check("busy_in_flight", busy, 1);
        check("ready_in_flight", sample_ready, 0);
      end
      if (!accepted && sample_valid && sample_ready) begin
        accepted = 1'b1;
        check("accept_cycle", c, with_clear ? N + 1 : 0);
        check("clears_before_accept", clr_cnt, with_clear ? N : 0);
      end
      if (dead && since_en == 16) check("timeout_not_yet", timeout_err, 0);
      if (dead && since_en == 17) begin
        check("timeout_set", timeout_err, 1);
        check("timeout_idle", busy, 0);
      end
      if (abort && en_cnt == 3 && since_en == 4) break;
    end
    if (abort) return;
    @(negedge clk);
    start_clear = 1'b0; sample_valid = 1'b0; state_ready = 1'b0;
    #1;
    check("idle_after", busy, 0);
    if (dead) begin
      check("timeout_en_count", en_cnt, 1);
    end else begin
      check("readout_done", done, 1);
      check("en_count", en_cnt, N);
      check("rd_count", rd_cnt, N);
    end
    if (hmode) check("hold_cycles", hold_cnt, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sample_valid = 1'b1; sample_data = 16'h0FFF; mask = 4'hF; state_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0;
    #1;
    check("post_reset_ready", sample_ready, 1);
    check("post_reset_busy", busy, 0);

    // clear and sample requested together: clear first, sample afterward
    run_sample(16'h0123, 4'b1011, 3, 1, 0, 0, 0);
    // canonical sample: din sequence 0x100, 0, 0x100, 0
    run_sample(16'h0100, 4'b0101, 4, 0, 0, 0, 0);
    // downstream stalls three cycles on node 2
    run_sample(16'h0ABC, 4'b1111, 2, 0, 0, 1, 0);
    // latency extremes: shortest, and longest that still beats the timeout
    run_sample(16'h0042, 4'b0110, 1, 0, 0, 0, 0);
    run_sample(16'h0777, 4'b1001, TO, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      run_sample(SW'($urandom), N'($urandom), $urandom_range(1, TO), 1'($urandom_range(0, 1)), 0, 0, 0);

    // reservoir never comes back: sticky timeout
    run_sample(16'h0555, 4'b1111, 5, 0, 1, 0, 0);
    run_sample(16'h0321, 4'b0011, 3, 0, 0, 0, 0);
    check("timeout_sticky", timeout_err, 1);

    // reset while waiting on node 2
    run_sample(16'h0999, 4'b1111, 10, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("abort");
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0; start_clear = 1'b0; state_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      observe();
      check("post_abort_busy", busy, 0);
    end
    check("post_abort_en_count", en_cnt, 3);
    run_sample(16'h0040, 4'b0001, 2, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
